seven_seg_scanner: RTL

Time-multiplexing controller for the board's shared 4-digit seven-segment display. It shares the single `io_7seg` segment bus among four digit positions, one slot at a time. Each digit is driven for a fixed dwell period, separated by an all-off blanking gap to prevent ghosting. Digit values are double-buffered so that updates land only on frame boundaries, which prevents tearing. It sits between the counter/datapath logic in `main` and the `io_7seg_select`/`io_7seg` pins, and replaces the static DIP-switch digit selection.

---
 rtl/seven_seg_scanner_if.sv | 22 ++
 rtl/seven_seg_scanner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// Signal bundle between the datapath and the time-multiplexed seven-segment scanner.
interface seven_seg_scanner_if;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic        load;
    logic        load_ack;
    logic        frame_start;
    logic [3:0]  io_7seg_select;
    logic [7:0]  io_7seg;

    modport master (
        output digits_in, dp_in, blank_in, lz_en, load,
        input  load_ack, frame_start, io_7seg_select, io_7seg
    );

    modport slave (
        input  digits_in, dp_in, blank_in, lz_en, load,
        output load_ack, frame_start, io_7seg_select, io_7seg
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit seven-segment scanner: blank gap + dwell per digit, double-buffered digit
// values committed only at frame boundaries, leading-zero suppression and blank override.
module seven_seg_scanner #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic               cu_clk,
    input  logic               btn_reset,
    seven_seg_scanner_if.slave bus
);
    localparam int CNT_MAX0 = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             frame_edge;
    logic             commit;

    logic        pending_q, pending_d;
    logic [15:0] stage_digits_q, stage_digits_d;
    logic [3:0]  stage_dp_q, stage_dp_d;
    logic [3:0]  stage_blank_q, stage_blank_d;
    logic [15:0] shadow_digits_q, shadow_digits_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [3:0]  shadow_blank_q, shadow_blank_d;

    logic [3:0]      select_q, select_d;
    logic [7:0]      seg_q, seg_d;
    logic            frame_start_q;
    logic            load_ack_q;
    logic [3:0][7:0] digit_seg;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    // The register set describes the current cycle; the first edge after reset enters
    // cycle 0 of frame 0 without advancing, so it counts as a frame boundary.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        frame_edge = 1'b0;
        if (!run_q) begin
            state_d    = HAS_BLANK ? ST_BLANK : ST_DRIVE;
            idx_d      = 2'd0;
            cnt_d      = '0;
            frame_edge = 1'b1;
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = ST_DRIVE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            if (cnt_q == DWELL_LAST) begin
                state_d    = HAS_BLANK ? ST_BLANK : ST_DRIVE;
                idx_d      = idx_q + 2'd1;
                cnt_d      = '0;
                frame_edge = (idx_q == 2'd3);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Commit reads the old staging contents, so a load on the boundary edge waits a frame.
    always_comb begin
        commit          = frame_edge & pending_q;
        stage_digits_d  = stage_digits_q;
        stage_dp_d      = stage_dp_q;
        stage_blank_d   = stage_blank_q;
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        shadow_blank_d  = shadow_blank_q;
        if (bus.load) begin
            stage_digits_d = bus.digits_in;
            stage_dp_d     = bus.dp_in;
            stage_blank_d  = bus.blank_in;
        end
        if (commit) begin
            shadow_digits_d = stage_digits_q;
            shadow_dp_d     = stage_dp_q;
            shadow_blank_d  = stage_blank_q;
        end
        pending_d = bus.load | (pending_q & ~commit);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] nib;
        logic       suppress;
        assign nib = shadow_digits_d[4*gi +: 4];
        if (gi == 0) begin : g_units
            assign suppress = 1'b0;
        end else begin : g_upper
            assign suppress = bus.lz_en && (shadow_digits_d[15:4*gi] == '0);
        end
        assign digit_seg[gi] = shadow_blank_d[gi] ? 8'hFF
                             : suppress           ? {~shadow_dp_d[gi], 7'h7F}
                             :                      ~{shadow_dp_d[gi], hex_to_seg(nib)};
    end

    always_comb begin
        select_d = 4'b1111;
        seg_d    = 8'hFF;
        if (state_d == ST_DRIVE) begin
            select_d[idx_d] = 1'b0;
            seg_d           = digit_seg[idx_d];
        end
    end

    always_ff @(posedge cu_clk) begin
        if (!btn_reset) begin
            state_q         <= ST_BLANK;
            idx_q           <= 2'd0;
            cnt_q           <= '0;
            run_q           <= 1'b0;
            pending_q       <= 1'b0;
            stage_digits_q  <= '0;
            stage_dp_q      <= '0;
            stage_blank_q   <= '0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            shadow_blank_q  <= '0;
            select_q        <= 4'b1111;
            seg_q           <= 8'hFF;
            frame_start_q   <= 1'b0;
            load_ack_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            run_q           <= 1'b1;
            pending_q       <= pending_d;
            stage_digits_q  <= stage_digits_d;
            stage_dp_q      <= stage_dp_d;
            stage_blank_q   <= stage_blank_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            shadow_blank_q  <= shadow_blank_d;
            select_q        <= select_d;
            seg_q           <= seg_d;
            frame_start_q   <= frame_edge;
            load_ack_q      <= commit;
        end
    end

    assign bus.io_7seg_select = select_q;
    assign bus.io_7seg        = seg_q;
    assign bus.frame_start    = frame_start_q;
    assign bus.load_ack       = load_ack_q;
endmodule
